// File: rtl/hmem_resp.sv
// rtl/hmem_resp.sv - memory-side line responder for the hmem h_* interface
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   h_addr/h_rd/h_wr    : line request from hmem (level, held until h_dv)
//   h_data_out          : writeback line from hmem
//   h_data_in/h_dv      : read line and one-cycle completion pulse
//   x_addr/x_data/x_wr  : external loader write (level, held until x_ack)
//   x_ack               : one-cycle loader write completion
//   inv/inv_addr        : one-cycle invalidate of a loader-written line
//   err                 : one-cycle protocol/range error
module hmem_resp #(
  parameter int LINE_W     = 256,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 8,
  parameter int WR_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       h_addr,
  input  logic              h_rd,
  input  logic              h_wr,
  input  logic [LINE_W-1:0] h_data_out,
  output logic [LINE_W-1:0] h_data_in,
  output logic              h_dv,
  input  logic [63:0]       x_addr,
  input  logic [LINE_W-1:0] x_data,
  input  logic              x_wr,
  output logic              x_ack,
  output logic [63:0]       inv_addr,
  output logic              inv,
  output logic              err
);

  localparam int OFF     = $clog2(LINE_W / 8);
  localparam int LA_W    = 64 - OFF;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  // Line offset bits never select anything; only the line address is kept.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{h_addr[OFF-1:0], x_addr[OFF-1:0]};

  logic [LINE_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LA_W-1:0]   la_q, la_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] h_data_in_q, h_data_in_d;
  logic              h_dv_q, h_dv_d;
  logic              x_ack_q, x_ack_d;
  logic              inv_q, inv_d;
  logic [63:0]       inv_addr_q, inv_addr_d;
  logic              err_q, err_d;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [LINE_W-1:0]     mem_wdata;

  function automatic logic in_range(input logic [LA_W-1:0] la);
    return la[LA_W-1:DEPTH_LOG2] == '0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] line_idx(input logic [LA_W-1:0] la);
    return la[DEPTH_LOG2-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    la_d        = la_q;
    wdata_d     = wdata_q;
    h_data_in_d = h_data_in_q;
    h_dv_d      = 1'b0;
    x_ack_d     = 1'b0;
    inv_d       = 1'b0;
    inv_addr_d  = inv_addr_q;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = line_idx(la_q);
    mem_wdata   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (h_wr) begin
          // Write wins over a simultaneous read; the overlap is flagged.
          la_d    = h_addr[63:OFF];
          wdata_d = h_data_out;
          cnt_d   = CNT_W'(WR_LAT - 1);
          err_d   = h_rd;
          state_d = WR_WAIT;
        end else if (h_rd) begin
          la_d    = h_addr[63:OFF];
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = RD_WAIT;
        end else if (x_wr && !x_ack_q) begin
          // x_wr is still high while x_ack is out; skip that cycle so one
          // held request commits only once.
          mem_we     = in_range(x_addr[63:OFF]);
          mem_widx   = line_idx(x_addr[63:OFF]);
          mem_wdata  = x_data;
          x_ack_d    = 1'b1;
          inv_d      = 1'b1;
          inv_addr_d = {x_addr[63:OFF], {OFF{1'b0}}};
          err_d      = !in_range(x_addr[63:OFF]);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          h_dv_d      = 1'b1;
          h_data_in_d = in_range(la_q) ? mem[line_idx(la_q)] : '0;
          err_d       = !in_range(la_q);
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          h_dv_d  = 1'b1;
          mem_we  = in_range(la_q);
          err_d   = !in_range(la_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // Hold here until the level request drops so it is served once.
        if (!h_rd && !h_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      la_q        <= '0;
      wdata_q     <= '0;
      h_data_in_q <= '0;
      h_dv_q      <= 1'b0;
      x_ack_q     <= 1'b0;
      inv_q       <= 1'b0;
      inv_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      la_q        <= la_d;
      wdata_q     <= wdata_d;
      h_data_in_q <= h_data_in_d;
      h_dv_q      <= h_dv_d;
      x_ack_q     <= x_ack_d;
      inv_q       <= inv_d;
      inv_addr_q  <= inv_addr_d;
      err_q       <= err_d;
    end
  end

  // Backing array is not cleared by reset; reset only blocks a commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_widx] <= mem_wdata;
  end

  assign h_data_in = h_data_in_q;
  assign h_dv      = h_dv_q;
  assign x_ack     = x_ack_q;
  assign inv       = inv_q;
  assign inv_addr  = inv_addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hmem_resp.sv
// tb/tb_hmem_resp.sv - directed self-checking bench for hmem_resp
module tb_hmem_resp;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  h_addr;
  logic         h_rd;
  logic         h_wr;
  logic [255:0] h_data_out;
  logic [255:0] h_data_in;
  logic         h_dv;
  logic [63:0]  x_addr;
  logic [255:0] x_data;
  logic         x_wr;
  logic         x_ack;
  logic [63:0]  inv_addr;
  logic         inv;
  logic         err;

  int n_vec = 0;
  int n_err = 0;
  int inv_cnt = 0;

  logic [255:0] pat_p, pat_q, pat_d, pat_x, pat_z;

  hmem_resp #(.LINE_W(256), .DEPTH_LOG2(12), .RD_LAT(8), .WR_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_data_out(h_data_out),
    .h_data_in(h_data_in), .h_dv(h_dv),
    .x_addr(x_addr), .x_data(x_data), .x_wr(x_wr), .x_ack(x_ack),
    .inv_addr(inv_addr), .inv(inv), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (inv) inv_cnt++;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic x_write(input logic [63:0] a, input logic [255:0] d, input logic [63:0] exp_inv);
    x_addr = a; x_data = d; x_wr = 1'b1;
    tick();
    check_val("x_ack", 256'(x_ack), 256'(1));
    check_val("inv", 256'(inv), 256'(1));
    check_val("inv_addr", 256'(inv_addr), 256'(exp_inv));
    x_wr = 1'b0;
    tick();
    check_val("x_ack_width", 256'({x_ack, inv}), 256'(0));
  endtask

  // Issue one h request, scramble the inputs after acceptance, then check
  // latency, data, error pulses and single-service under a held request.
  task automatic do_req(input string tag, input logic wr, input logic rd,
                        input logic [63:0] a, input logic [255:0] d, input int hold,
                        input int exp_lat, input logic [255:0] exp_data,
                        input logic exp_err_acc, input logic exp_err_dv);
    int lat;
    int extra;
    logic err_acc;
    h_addr = a; h_data_out = d; h_wr = wr; h_rd = rd;
    tick();
    err_acc = err;
    h_addr = a ^ 64'h0000_0000_0000_0FE0;
    h_data_out = ~d;
    lat = 0;
    while (!h_dv && lat < 50) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, 256'(lat), 256'(exp_lat));
    check_val({tag, "_data"}, h_data_in, exp_data);
    check_val({tag, "_err_acc"}, 256'(err_acc), 256'(exp_err_acc));
    check_val({tag, "_err_dv"}, 256'(err), 256'(exp_err_dv));
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (h_dv) extra++;
    end
    h_wr = 1'b0; h_rd = 1'b0;
    tick();
    if (h_dv) extra++;
    check_val({tag, "_extra_dv"}, 256'(extra), 256'(0));
  endtask

  initial begin
    int n;
    int early;
    int dv_seen;
    int inv_before;
    pat_p = {4{64'h0123_4567_89AB_CDEF}};
    pat_q = {4{64'hFEDC_BA98_7654_3210}};
    pat_d = {8{32'hC0DE_0020}};
    pat_x = {8{32'h5A5A_0300}};
    pat_z = {8{32'hDEAD_BEEF}};
    rst = 1'b1; h_addr = '0; h_rd = 1'b0; h_wr = 1'b0; h_data_out = '0;
    x_addr = '0; x_data = '0; x_wr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_h_dv", 256'(h_dv), 256'(0));
    check_val("rst_h_data_in", h_data_in, 256'(0));
    check_val("rst_inv_addr", 256'(inv_addr), 256'(0));
    check_val("rst_pulses", 256'({x_ack, inv, err}), 256'(0));
    tick();

    // Preload line 5, read it back through an unaligned address.
    x_write(64'hA0, pat_p, 64'hA0);
    do_req("rd_a7", 1'b0, 1'b1, 64'hA7, '0, 0, 8, pat_p, 1'b0, 1'b0);

    // hmem write then read; h_data_in holds the previous read across the write.
    inv_before = inv_cnt;
    do_req("wr_40", 1'b1, 1'b0, 64'h40, pat_q, 0, 4, pat_p, 1'b0, 1'b0);
    do_req("rd_40", 1'b0, 1'b1, 64'h40, '0, 0, 8, pat_q, 1'b0, 1'b0);
    check_val("no_inv_on_hwr", 256'(inv_cnt), 256'(inv_before));

    // Level-held read served once; the next one goes straight through.
    do_req("hold_rd", 1'b0, 1'b1, 64'h40, '0, 5, 8, pat_q, 1'b0, 1'b0);
    do_req("after_hold", 1'b0, 1'b1, 64'hA0, '0, 0, 8, pat_p, 1'b0, 1'b0);

    // Simultaneous rd/wr: write path, error at acceptance.
    do_req("both_20", 1'b1, 1'b1, 64'h20, pat_d, 0, 4, pat_p, 1'b1, 1'b0);
    do_req("rd_20", 1'b0, 1'b1, 64'h20, '0, 0, 8, pat_d, 1'b0, 1'b0);

    // Out of range: read returns zero with err, write aliasing line 5 is dropped.
    do_req("oor_rd", 1'b0, 1'b1, 64'h2_0000, '0, 0, 8, 256'(0), 1'b0, 1'b1);
    do_req("oor_wr", 1'b1, 1'b0, 64'h2_00A0, ~pat_p, 0, 4, 256'(0), 1'b0, 1'b1);
    do_req("rd_a0_keep", 1'b0, 1'b1, 64'hA0, '0, 0, 8, pat_p, 1'b0, 1'b0);

    // Reset three cycles into a write of line 2 aborts it.
    h_addr = 64'h40; h_data_out = pat_z; h_wr = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1; h_wr = 1'b0;
    dv_seen = 0;
    repeat (2) begin
      tick();
      if (h_dv) dv_seen++;
    end
    rst = 1'b0;
    repeat (6) begin
      tick();
      if (h_dv) dv_seen++;
    end
    check_val("rst_abort_dv", 256'(dv_seen), 256'(0));
    do_req("rd_40_kept", 1'b0, 1'b1, 64'h40, '0, 0, 8, pat_q, 1'b0, 1'b0);

    // Loader write raised during RD_WAIT waits for the read to finish.
    h_addr = 64'hA0; h_rd = 1'b1;
    tick();
    x_addr = 64'h30F; x_data = pat_x; x_wr = 1'b1;
    n = 0; early = 0;
    while (!h_dv && n < 50) begin
      tick();
      n++;
      if (x_ack) early++;
    end
    check_val("xrd_lat", 256'(n), 256'(8));
    check_val("xrd_data", h_data_in, pat_p);
    check_val("xrd_early_ack", 256'(early), 256'(0));
    h_rd = 1'b0;
    n = 0;
    while (!x_ack && n < 20) begin
      tick();
      n++;
    end
    check_val("x_after_rd_lat", 256'(n), 256'(2));
    check_val("x_after_rd_inv", 256'({inv, inv_addr}), {191'(0), 1'b1, 64'h300});
    x_wr = 1'b0;
    tick();
    do_req("rd_300", 1'b0, 1'b1, 64'h300, '0, 0, 8, pat_x, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hmem_resp.md
Name: hmem_resp

Overview:
Memory-side responder for the h_* line interface driven by hmem (the L1 I/D cache hierarchy). It serves line reads and line writebacks from a line-organised backing array, with programmable read and write latency. A secondary external write port (debug/DMA loader) updates the array and issues an invalidate (inv/inv_addr) back to hmem so stale L1 lines are dropped.

Parameters:
LINE_W, `hmem_line, line width in bits (power of two, >=64)
DEPTH_LOG2, 12, log2 of number of lines in the backing array
RD_LAT, 8, cycles from read acceptance to h_dv (>=1)
WR_LAT, 4, cycles from write acceptance to h_dv (>=1)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
h_addr  input  64  byte address of requested line (offset bits ignored)
h_rd  input  1  read request, level, held until h_dv
h_wr  input  1  write request, level, held until h_dv
h_data_out  input  LINE_W  write data from hmem, stable while h_wr
h_data_in  output  LINE_W  read data to hmem, valid when h_dv
h_dv  output  1  one-cycle completion pulse (read or write)
x_addr  input  64  external write byte address
x_data  input  LINE_W  external write line data
x_wr  input  1  external write request, level, held until x_ack
x_ack  output  1  one-cycle external write completion pulse
inv_addr  output  64  line-aligned address to invalidate in hmem
inv  output  1  one-cycle invalidate pulse
err  output  1  one-cycle protocol/range error pulse

Behaviour:
- OFF = log2(LINE_W/8); index = addr[OFF+DEPTH_LOG2-1:OFF]; in-range iff addr[63:OFF+DEPTH_LOG2]==0.
- Reset: state IDLE, counter 0; h_dv, x_ack, inv, err = 0; h_data_in = 0; inv_addr = 0. Array contents not cleared. Reset mid-transaction aborts it, no h_dv; a pending write is not committed.
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE: h_wr=1 -> latch addr/data, cnt=WR_LAT-1, WR_WAIT. Else h_rd=1 -> latch addr, cnt=RD_LAT-1, RD_WAIT. h_rd&h_wr both high: write wins, err pulses same cycle. Else x_wr=1 -> commit x_data at x_addr this cycle; next cycle x_ack=1 and inv=1 with inv_addr = x_addr with low OFF bits zeroed. Remain IDLE.
- h-side priority: x_wr arriving with an h request in IDLE waits; x_wr never accepted outside IDLE.
- RD_WAIT/WR_WAIT: decrement cnt; at cnt==0 move to DONE with h_dv=1 in the same edge. Request accepted at edge t -> h_dv high during cycle t+LAT.
- Read: h_data_in = array[index] captured at the edge h_dv rises, held until the next read completes. Out of range: h_data_in = 0, err pulses with h_dv.
- Write: array[index] written at the edge h_dv rises using latched data. Out of range: write dropped, err pulses with h_dv. Writes from hmem do not raise inv.
- DONE: h_dv low; stay until h_rd==0 and h_wr==0, then IDLE. A new request needs at least one low cycle between transactions, so a level-held request is never served twice.
- Changes on h_addr/h_data_out after acceptance are ignored (latched).
- err, h_dv, x_ack and inv are exactly one cycle wide.

Test Plan:
- Reset, preload line 5 via x_wr (x_addr=0xA0 for LINE_W=256, x_data=pattern P) -> x_ack and inv pulse together one cycle after acceptance, inv_addr=0xA0. Then h_rd at 0xA7 -> h_dv exactly RD_LAT=8 cycles after acceptance, h_data_in=P.
- h_wr at 0x40, data Q, then h_rd at 0x40 -> h_dv 4 cycles after write acceptance, read returns Q, inv never asserts.
- h_rd held high 5 cycles after h_dv -> only one h_dv; next request accepted in the cycle after h_rd falls.
- h_rd and h_wr together at 0x20 -> err pulses at acceptance, write path taken (h_dv after 4 cycles), readback of 0x20 returns the write data.
- h_rd at 1<<(OFF+DEPTH_LOG2) -> h_dv after 8 cycles with h_data_in=0 and err=1 in the same cycle. Out-of-range h_wr leaves the array unchanged.
- rst asserted 3 cycles into a write to line 2 -> no h_dv, line 2 keeps its old value. x_wr raised during RD_WAIT -> x_ack only after the read completes and the FSM returns to IDLE.
